// File: rtl/cam_cmd_sequencer.sv
// Command sequencer between a host AXI-Stream command port and a CAM block.
// Forwards legal beats one cycle later, tracks in-flight searches and buffers results in order.
module cam_cmd_sequencer #(
   parameter int unsigned DATA_WIDTH  = 520,
   parameter int unsigned CAM_SIZE    = 128,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned CAM_LATENCY = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  cam_tvalid,
   output logic [DATA_WIDTH-1:0] cam_tdata,
   output logic                  cam_areset,
   input  logic                  cam_rvalid,
   input  logic [DATA_WIDTH-1:0] cam_rdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  done,
   output logic                  err_overflow,
   output logic                  err_opcode
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned OCC_W  = CNT_W + 1;
   localparam int unsigned LOADS  = CAM_SIZE / 16;
   localparam int unsigned LOAD_W = $clog2(LOADS + 1);

   localparam logic [3:0] OP_RESET_ALL  = 4'h7;
   localparam logic [3:0] OP_UPDATE_ALL = 4'h1;
   localparam logic [3:0] OP_UPDATE_DUP = 4'h8;
   localparam logic [3:0] OP_SEARCH_ONE = 4'h4;
   localparam logic [3:0] OP_SEARCH_MQ  = 4'h5;
   localparam logic [3:0] OP_EOS        = 4'hF;

   if (CAM_LATENCY < 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("cam_cmd_sequencer: illegal parameter set");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_RST_GAP, ST_DRAIN, ST_DONE} state_t;

   state_t                state;
   logic                  ready_hold;
   logic [LOAD_W-1:0]     load_cnt;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W-1:0]      fifo_count;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [3:0]       head_op;
   logic             head_result;
   logic [OCC_W-1:0] occupancy;
   logic             accept, fwd, issue, load_inc, ovf, illegal, push, pop, stray;

   // Searches and EOS need a guaranteed FIFO slot before they may be accepted.
   always_comb begin
      head_op       = s_axis_tdata[DATA_WIDTH-2 -: 4];
      head_result   = (head_op == OP_SEARCH_ONE) || (head_op == OP_SEARCH_MQ) || (head_op == OP_EOS);
      occupancy     = OCC_W'(fifo_count) + OCC_W'(inflight) + OCC_W'(1);
      s_axis_tready = (state == ST_IDLE) && !ready_hold &&
                      (!head_result || (occupancy <= OCC_W'(FIFO_DEPTH)));
      accept        = s_axis_tvalid && s_axis_tready;
   end

   // Accepted-beat decode.
   always_comb begin
      fwd      = 1'b0;
      issue    = 1'b0;
      load_inc = 1'b0;
      ovf      = 1'b0;
      illegal  = 1'b0;
      if (accept) begin
         case (head_op)
            OP_RESET_ALL: fwd = 1'b1;
            OP_UPDATE_ALL, OP_UPDATE_DUP: begin
               if (load_cnt == LOAD_W'(LOADS)) begin
                  ovf = 1'b1;
               end else begin
                  fwd      = 1'b1;
                  load_inc = 1'b1;
               end
            end
            OP_SEARCH_ONE, OP_SEARCH_MQ, OP_EOS: begin
               fwd   = 1'b1;
               issue = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      push          = cam_rvalid && (inflight != '0);
      stray         = cam_rvalid && (inflight == '0);
      m_axis_tvalid = (fifo_count != '0);
      pop           = m_axis_tvalid && m_axis_tready;
      m_axis_tdata  = mem[rd_ptr];
      m_axis_tlast  = (m_axis_tdata[DATA_WIDTH-2 -: 4] == OP_EOS);
   end

   // CAM reset follows host reset by one cycle; host port stays closed one cycle longer.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cam_areset <= 1'b1;
         ready_hold <= 1'b1;
      end else begin
         cam_areset <= 1'b0;
         ready_hold <= cam_areset;
      end
   end

   // Control FSM, forwarding register, load counter and sticky errors.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= ST_IDLE;
         cam_tvalid   <= 1'b0;
         cam_tdata    <= '0;
         load_cnt     <= '0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         err_opcode   <= 1'b0;
      end else begin
         cam_tvalid <= fwd;
         cam_tdata  <= fwd ? s_axis_tdata : '0;
         done       <= 1'b0;
         if (accept && head_op == OP_RESET_ALL) begin
            load_cnt <= '0;
         end else if (load_inc) begin
            load_cnt <= load_cnt + LOAD_W'(1);
         end
         if (ovf) err_overflow <= 1'b1;
         if (illegal || stray) err_opcode <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept && head_op == OP_RESET_ALL) state <= ST_RST_GAP;
               else if (accept && head_op == OP_EOS) state <= ST_DRAIN;
            end
            ST_RST_GAP: state <= ST_IDLE;
            ST_DRAIN: begin
               if (inflight == '0 && fifo_count == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // In-flight and result FIFO bookkeeping; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (issue && !push) inflight <= inflight + CNT_W'(1);
         else if (!issue && push) inflight <= inflight - CNT_W'(1);
         if (push && !pop) fifo_count <= fifo_count + CNT_W'(1);
         else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr] <= cam_rdata;
   end

endmodule

// File: doc/cam_cmd_sequencer.md
CAM_CMD_SEQUENCER -- requirements
Module: cam_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 520: width of every command and result beat; opcode field is bits [DATA_WIDTH-2:DATA_WIDTH-5].
REQ-002 SHALL have parameter CAM_SIZE, default 128: number of CAM entries; one update beat loads 16 entries.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=4): depth of the result FIFO.
REQ-004 SHALL have parameter CAM_LATENCY, default 2: cycles from cam_tvalid to cam_rvalid.
REQ-005 aclk  in  1  single clock; all logic on its rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 s_axis_tvalid/s_axis_tready/s_axis_tdata  in/out/in  1/1/DATA_WIDTH  host command stream.
REQ-008 cam_tvalid/cam_tdata  out/out  1/DATA_WIDTH  beat driven into the CAM block; no backpressure.
REQ-009 cam_areset  out  1  active-high reset to the CAM block, equals registered !aresetn.
REQ-010 cam_rvalid/cam_rdata  in/in  1/DATA_WIDTH  CAM result beat.
REQ-011 m_axis_tvalid/m_axis_tready/m_axis_tdata/m_axis_tlast  out/in/out/out  1/1/DATA_WIDTH/1  result stream to host.
REQ-012 done  out  1  one-cycle pulse after end-of-stream fully drained.
REQ-013 err_overflow / err_opcode  out  1 each  sticky error flags.

Function
REQ-014 Opcodes: RESET_ALL=7, UPDATE_ALL=1, UPDATE_DUPLICATE=8, SEARCH_ONE=4, SEARCH_MQ=5, END_OF_STREAM=4'hF; all others illegal.
REQ-015 FSM states SHALL be IDLE, RST_GAP, DRAIN, DONE; reset state IDLE.
REQ-016 A host beat is accepted when s_axis_tvalid && s_axis_tready; an accepted legal beat SHALL appear on cam_tvalid/cam_tdata unmodified exactly 1 cycle later; cam_tvalid low and cam_tdata opcode field 0 (IDLE) otherwise.
REQ-017 s_axis_tready SHALL be high only in IDLE, and for SEARCH_ONE/SEARCH_MQ/END_OF_STREAM heads only when fifo_count + inflight + 1 <= FIFO_DEPTH (combinational on head opcode).
REQ-018 inflight counter SHALL +1 per search/EOS beat issued to the CAM, -1 per cam_rvalid; simultaneous +1/-1 leaves it unchanged; never exceeds FIFO_DEPTH.
REQ-019 Accepted RESET_ALL SHALL be forwarded, clear load_cnt to 0, and move IDLE->RST_GAP; RST_GAP holds tready low for 1 cycle then returns to IDLE.
REQ-020 load_cnt SHALL count forwarded UPDATE_ALL/UPDATE_DUPLICATE beats; once load_cnt == CAM_SIZE/16, further update beats SHALL be accepted but dropped (not forwarded) and set err_overflow.
REQ-021 Illegal opcodes SHALL be accepted, dropped, and set err_opcode.
REQ-022 Accepted END_OF_STREAM SHALL be forwarded and move IDLE->DRAIN; DRAIN holds tready low until inflight==0, fifo empty and no m_axis beat pending, then ->DONE; DONE asserts done for 1 cycle and ->IDLE.
REQ-023 Every cam_rvalid beat SHALL be written to the result FIFO; overflow is impossible by REQ-017; if cam_rvalid arrives with inflight==0 the beat is dropped and err_opcode set.
REQ-024 m_axis_tdata SHALL be FIFO head; m_axis_tvalid = FIFO non-empty; pop on m_axis_tvalid && m_axis_tready; simultaneous push and pop keeps fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 m_axis_tlast SHALL be 1 exactly when head opcode field == 4'hF.
REQ-026 Result order SHALL equal issue order.

Reset
REQ-027 While aresetn low: FSM IDLE, cam_tvalid 0, cam_areset 1, s_axis_tready 0, m_axis_tvalid 0, done 0, inflight/fifo_count/load_cnt 0, both error flags 0.
REQ-028 Reset asserted mid-operation SHALL discard FIFO contents and in-flight results; cam_areset SHALL deassert 1 cycle after aresetn rises; s_axis_tready SHALL stay low for 1 cycle after cam_areset deasserts.

Verification
V-1 RESET_ALL then 8 UPDATE_ALL beats (CAM_SIZE=128) -> 9 cam_tvalid beats, each 1 cycle after acceptance, 1 bubble after RESET_ALL, err_overflow 0.
V-2 9th UPDATE_ALL after V-1 -> not forwarded, err_overflow=1 sticky, load_cnt stays 8.
V-3 12 back-to-back SEARCH_MQ with m_axis_tready=0, FIFO_DEPTH=8 -> exactly 8 forwarded, tready low; raise m_axis_tready -> remaining 4 issue, 12 results in order.
V-4 3 SEARCH_ONE then END_OF_STREAM, m_axis_tready=1 -> 4 results, tlast on 4th only, done pulses once after last pop, FSM back to IDLE.
V-5 opcode 4'h2 -> dropped, no cam_tvalid, err_opcode=1.
V-6 aresetn low for 1 cycle with 3 results in FIFO and 2 in flight -> m_axis_tvalid 0, counters 0, late cam_rvalid beats dropped under cam_areset, next search returns 1 result.
